el2_iccm_bank_array: RTL and testbench

EL2_ICCM_BANK_ARRAY -- requirements
Module: el2_iccm_bank_array

---
 rtl/el2_pkg.sv | 17 +
 rtl/el2_ram.sv | 42 ++++
 rtl/el2_iccm_bank_array.sv | 186 ++++++++++++++++++
 tb/tb_el2_iccm_bank_array.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | el2_pkg : shared types and constants for the ICCM bank array             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package el2_pkg;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      READY = 1'b1
   } el2_iccm_state_e;

   localparam int EL2_RD_LAT_1 = 1;
   localparam int EL2_RD_LAT_2 = 2;

endpackage
`default_nettype wire

// File: rtl/el2_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | el2_ram : single-port synchronous RAM, registered read, memory unreset   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module el2_ram
   import el2_pkg::*;
#(
   parameter int WIDTH      = 39,
   parameter int DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [DEPTH_BITS-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register only moves on a read, so the last row read stays visible.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/el2_iccm_bank_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | el2_iccm_bank_array : banked ICCM with zeroize sweep and bit-flip inject |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module el2_iccm_bank_array
   import el2_pkg::*;
#(
   parameter int  NUM_BANKS  = 4,
   parameter int  INDEX_BITS = 10,
   parameter int  DATA_W     = 32,
   parameter int  ECC_W      = 7,
   parameter int  RD_LAT     = 1,
   parameter int  INIT_EN    = 1,
   localparam int C_RW       = DATA_W + ECC_W,
   localparam int C_BW       = $clog2(NUM_BANKS),
   localparam int C_IBW      = $clog2(C_RW)
) (
   input  logic                            clk,
   input  logic                            rst_l,
   input  logic [NUM_BANKS-1:0]            bank_clken,
   input  logic [NUM_BANKS-1:0]            bank_wren,
   input  logic [NUM_BANKS*INDEX_BITS-1:0] bank_addr,
   input  logic [NUM_BANKS*DATA_W-1:0]     bank_wr_data,
   input  logic [NUM_BANKS*ECC_W-1:0]      bank_wr_ecc,
   output logic [NUM_BANKS*DATA_W-1:0]     bank_dout,
   output logic [NUM_BANKS*ECC_W-1:0]      bank_ecc,
   output logic [NUM_BANKS-1:0]            bank_rd_valid,
   output logic                            init_done,
   input  logic                            inj_req,
   input  logic [C_BW-1:0]                 inj_bank,
   input  logic [C_IBW-1:0]                inj_bit,
   output logic                            inj_pend
);

   el2_iccm_state_e       state_q, state_d;
   logic [INDEX_BITS-1:0] row_q, row_d;
   logic                  init_done_q, init_done_d;
   logic                  inj_pend_q, inj_pend_d;
   logic [C_BW-1:0]       inj_bank_q, inj_bank_d;
   logic [C_IBW-1:0]      inj_bit_q, inj_bit_d;

   logic                  w_sweep;
   logic                  w_consume;
   logic [NUM_BANKS-1:0]  w_ext_rd;
   logic [NUM_BANKS-1:0]  w_ext_wr;
   logic [NUM_BANKS-1:0]  w_inj_hit;
   logic [C_RW-1:0]       w_flip;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= (INIT_EN != 0) ? INIT : READY;
         row_q       <= '0;
         init_done_q <= 1'b0;
         inj_pend_q  <= 1'b0;
         inj_bank_q  <= '0;
         inj_bit_q   <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         init_done_q <= init_done_d;
         inj_pend_q  <= inj_pend_d;
         inj_bank_q  <= inj_bank_d;
         inj_bit_q   <= inj_bit_d;
      end
   end

   // init_done trails READY by one cycle so the last swept row settles first.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      init_done_d = (state_q == READY);
      w_sweep     = 1'b0;
      case (state_q)
         INIT: begin
            w_sweep = 1'b1;
            row_d   = row_q + INDEX_BITS'(1);
            if (row_q == {INDEX_BITS{1'b1}}) begin
               state_d = READY;
            end
         end
         READY:   state_d = READY;
         default: state_d = READY;
      endcase
   end

   // A fresh request always wins, so a coincident consuming write uses the old target.
   always_comb begin
      w_ext_rd  = {NUM_BANKS{init_done_q}} & bank_clken & ~bank_wren;
      w_ext_wr  = {NUM_BANKS{init_done_q}} & bank_clken & bank_wren;
      w_inj_hit = '0;
      w_inj_hit[inj_bank_q] = inj_pend_q;
      w_consume = |(w_inj_hit & w_ext_wr);
      w_flip    = '0;
      if (int'(inj_bit_q) < C_RW) begin
         w_flip[inj_bit_q] = 1'b1;
      end
      inj_pend_d = inj_pend_q;
      inj_bank_d = inj_bank_q;
      inj_bit_d  = inj_bit_q;
      if (inj_req) begin
         inj_pend_d = 1'b1;
         inj_bank_d = inj_bank;
         inj_bit_d  = inj_bit;
      end else if (w_consume) begin
         inj_pend_d = 1'b0;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic                  w_en;
      logic                  w_we;
      logic [INDEX_BITS-1:0] w_addr;
      logic [C_RW-1:0]       w_wdata;
      logic [C_RW-1:0]       w_rdata;
      logic [C_RW-1:0]       w_out;
      logic                  w_vld;
      logic                  valid1_q;

      always_comb begin
         w_en    = w_sweep | w_ext_rd[b] | w_ext_wr[b];
         w_we    = w_sweep | w_ext_wr[b];
         w_addr  = w_sweep ? row_q : bank_addr[b*INDEX_BITS +: INDEX_BITS];
         w_wdata = '0;
         if (!w_sweep) begin
            w_wdata = {bank_wr_ecc[b*ECC_W +: ECC_W], bank_wr_data[b*DATA_W +: DATA_W]};
            if (w_inj_hit[b]) begin
               w_wdata = w_wdata ^ w_flip;
            end
         end
      end

      el2_ram #(
         .WIDTH      (C_RW),
         .DEPTH_BITS (INDEX_BITS)
      ) u_ram (
         .clk     (clk),
         .rst_l   (rst_l),
         .en_i    (w_en),
         .we_i    (w_we),
         .addr_i  (w_addr),
         .wdata_i (w_wdata),
         .rdata_o (w_rdata)
      );

      always_ff @(posedge clk or negedge rst_l) begin
         if (!rst_l) begin
            valid1_q <= 1'b0;
         end else begin
            valid1_q <= w_ext_rd[b];
         end
      end

      if (RD_LAT >= EL2_RD_LAT_2) begin : g_lat2
         logic [C_RW-1:0] out_q;
         logic            valid2_q;

         always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
               out_q    <= '0;
               valid2_q <= 1'b0;
            end else begin
               valid2_q <= valid1_q;
               if (valid1_q) begin
                  out_q <= w_rdata;
               end
            end
         end

         assign w_out = out_q;
         assign w_vld = valid2_q;
      end else begin : g_lat1
         assign w_out = w_rdata;
         assign w_vld = valid1_q;
      end

      assign bank_dout[b*DATA_W +: DATA_W] = w_out[DATA_W-1:0];
      assign bank_ecc[b*ECC_W +: ECC_W]    = w_out[C_RW-1:DATA_W];
      assign bank_rd_valid[b]              = w_vld;
   end

   assign init_done = init_done_q;
   assign inj_pend  = inj_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_el2_iccm_bank_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_el2_iccm_bank_array : directed bench, RD_LAT=1 and RD_LAT=2 side by side |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_el2_iccm_bank_array;

   localparam int NB = 4;
   localparam int IB = 4;
   localparam int DW = 32;
   localparam int EW = 7;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic [NB-1:0]    clken, wren;
   logic [NB*IB-1:0] addr;
   logic [NB*DW-1:0] wdata;
   logic [NB*EW-1:0] wecc;
   logic             inj_req;
   logic [1:0]       inj_bank;
   logic [5:0]       inj_bit;

   logic [NB*DW-1:0] dout1, dout2;
   logic [NB*EW-1:0] ecc1, ecc2;
   logic [NB-1:0]    vld1, vld2;
   logic             done1, done2, pend1, pend2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   el2_iccm_bank_array #(
      .NUM_BANKS(NB), .INDEX_BITS(IB), .DATA_W(DW), .ECC_W(EW), .RD_LAT(1), .INIT_EN(1)
   ) u_dut1 (
      .clk(clk), .rst_l(rst_l), .bank_clken(clken), .bank_wren(wren), .bank_addr(addr),
      .bank_wr_data(wdata), .bank_wr_ecc(wecc), .bank_dout(dout1), .bank_ecc(ecc1),
      .bank_rd_valid(vld1), .init_done(done1), .inj_req(inj_req), .inj_bank(inj_bank),
      .inj_bit(inj_bit), .inj_pend(pend1)
   );

   el2_iccm_bank_array #(
      .NUM_BANKS(NB), .INDEX_BITS(IB), .DATA_W(DW), .ECC_W(EW), .RD_LAT(2), .INIT_EN(1)
   ) u_dut2 (
      .clk(clk), .rst_l(rst_l), .bank_clken(clken), .bank_wren(wren), .bank_addr(addr),
      .bank_wr_data(wdata), .bank_wr_ecc(wecc), .bank_dout(dout2), .bank_ecc(ecc2),
      .bank_rd_valid(vld2), .init_done(done2), .inj_req(inj_req), .inj_bank(inj_bank),
      .inj_bit(inj_bit), .inj_pend(pend2)
   );

   function automatic logic [DW-1:0] md(input int b, input int r);
      return 32'hC0DE0000 | 32'(b << 8) | 32'(r);
   endfunction

   function automatic logic [EW-1:0] me(input int b, input int r);
      return 7'((b << 4) | r);
   endfunction

   task automatic idle();
      clken   = '0;
      wren    = '0;
      inj_req = 1'b0;
   endtask

   task automatic set_bank(input int b, input logic we, input int row,
                           input logic [DW-1:0] d, input logic [EW-1:0] e);
      clken[b]             = 1'b1;
      wren[b]              = we;
      addr[b*IB +: IB]     = IB'(row);
      wdata[b*DW +: DW]    = d;
      wecc[b*EW +: EW]     = e;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n;
      idle();
      addr = '0; wdata = '0; wecc = '0; inj_bank = '0; inj_bit = '0;
      rst_l = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({done1, done2, pend1, pend2} !== 4'b0 || vld1 !== '0 || vld2 !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: done=%b%b pend=%b%b vld=%h/%h, expected all zero",
                  done1, done2, pend1, pend2, vld1, vld2);
      end
      checks++;
      if (dout1 !== '0 || dout2 !== '0 || ecc1 !== '0 || ecc2 !== '0) begin
         errors++;
         $display("FAIL reset_data: dout=%h/%h ecc=%h/%h, expected zero", dout1, dout2, ecc1, ecc2);
      end
      rst_l = 1'b1;
      n = 0;
      while (!done1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 17) begin
         errors++;
         $display("FAIL init_latency: init_done after %0d cycles, expected 17", n);
      end
      checks++;
      if (done2 !== 1'b1) begin
         errors++;
         $display("FAIL init_done_lat2: got %b, expected 1", done2);
      end
   endtask

   task automatic test_init_zero();
      for (int r = 0; r < 16; r++) begin
         idle();
         for (int b = 0; b < NB; b++) set_bank(b, 1'b0, r, '0, '0);
         tick();
         checks++;
         if (vld1 !== 4'hF || dout1 !== '0 || ecc1 !== '0) begin
            errors++;
            $display("FAIL init_row_lat1 row %0d: vld=%h dout=%h ecc=%h, expected F/0/0", r, vld1, dout1, ecc1);
         end
         idle();
         tick();
         checks++;
         if (vld2 !== 4'hF || dout2 !== '0 || ecc2 !== '0) begin
            errors++;
            $display("FAIL init_row_lat2 row %0d: vld=%h dout=%h ecc=%h, expected F/0/0", r, vld2, dout2, ecc2);
         end
      end
   endtask

   task automatic test_write_read();
      idle();
      set_bank(2, 1'b1, 5, 32'hDEADBEEF, 7'h55);
      tick();
      checks++;
      if (vld1 !== '0 || vld2 !== '0 || dout1[2*DW +: DW] !== 32'h0) begin
         errors++;
         $display("FAIL write_quiet: vld=%h/%h dout2=%h, expected 0/0/0", vld1, vld2, dout1[2*DW +: DW]);
      end
      idle();
      set_bank(2, 1'b0, 5, '0, '0);
      tick();
      checks++;
      if (vld1 !== 4'b0100 || dout1[2*DW +: DW] !== 32'hDEADBEEF || ecc1[2*EW +: EW] !== 7'h55 || vld2 !== '0) begin
         errors++;
         $display("FAIL read_lat1: vld=%h data=%h ecc=%h vld2=%h, expected 4/deadbeef/55/0",
                  vld1, dout1[2*DW +: DW], ecc1[2*EW +: EW], vld2);
      end
      idle();
      tick();
      checks++;
      if (vld1 !== '0 || dout1[2*DW +: DW] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_hold_lat1: vld=%h data=%h, expected 0/deadbeef", vld1, dout1[2*DW +: DW]);
      end
      checks++;
      if (vld2 !== 4'b0100 || dout2[2*DW +: DW] !== 32'hDEADBEEF || ecc2[2*EW +: EW] !== 7'h55) begin
         errors++;
         $display("FAIL read_lat2: vld=%h data=%h ecc=%h, expected 4/deadbeef/55",
                  vld2, dout2[2*DW +: DW], ecc2[2*EW +: EW]);
      end
      idle();
      wren[3] = 1'b1;
      addr[3*IB +: IB] = 4'd2;
      wdata[3*DW +: DW] = 32'hFFFFFFFF;
      wecc[3*EW +: EW] = 7'h7F;
      tick();
      idle();
      set_bank(3, 1'b0, 2, '0, '0);
      tick();
      checks++;
      if (vld1 !== 4'b1000 || dout1[3*DW +: DW] !== 32'h0 || ecc1[3*EW +: EW] !== 7'h0) begin
         errors++;
         $display("FAIL wren_no_clken: vld=%h data=%h ecc=%h, expected 8/0/0",
                  vld1, dout1[3*DW +: DW], ecc1[3*EW +: EW]);
      end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [NB*DW-1:0] exp_d;
      logic [NB*EW-1:0] exp_e;
      int cnt1 [NB];
      int cnt2 [NB];
      for (int b = 0; b < NB; b++) begin
         cnt1[b] = 0;
         cnt2[b] = 0;
      end
      for (int i = 0; i < 8; i++) begin
         idle();
         for (int b = 0; b < NB; b++) set_bank(b, 1'b1, (i + 4*b) % 16, md(b, (i + 4*b) % 16), me(b, (i + 4*b) % 16));
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         idle();
         if (i < 8) begin
            for (int b = 0; b < NB; b++) set_bank(b, 1'b0, (i + 4*b) % 16, '0, '0);
         end
         tick();
         for (int b = 0; b < NB; b++) begin
            cnt1[b] += int'(vld1[b]);
            cnt2[b] += int'(vld2[b]);
         end
         if (i < 8) begin
            for (int b = 0; b < NB; b++) begin
               exp_d[b*DW +: DW] = md(b, (i + 4*b) % 16);
               exp_e[b*EW +: EW] = me(b, (i + 4*b) % 16);
            end
            checks++;
            if (vld1 !== 4'hF || dout1 !== exp_d || ecc1 !== exp_e) begin
               errors++;
               $display("FAIL b2b_lat1 cyc %0d: vld=%h dout=%h ecc=%h, expected F %h %h", i, vld1, dout1, ecc1, exp_d, exp_e);
            end
         end
         if (i >= 1 && i < 9) begin
            for (int b = 0; b < NB; b++) begin
               exp_d[b*DW +: DW] = md(b, (i - 1 + 4*b) % 16);
               exp_e[b*EW +: EW] = me(b, (i - 1 + 4*b) % 16);
            end
            checks++;
            if (vld2 !== 4'hF || dout2 !== exp_d || ecc2 !== exp_e) begin
               errors++;
               $display("FAIL b2b_lat2 cyc %0d: vld=%h dout=%h ecc=%h, expected F %h %h", i, vld2, dout2, ecc2, exp_d, exp_e);
            end
         end
      end
      for (int b = 0; b < NB; b++) begin
         checks++;
         if (cnt1[b] !== 8 || cnt2[b] !== 8) begin
            errors++;
            $display("FAIL b2b_pulses bank %0d: got %0d/%0d, expected 8/8", b, cnt1[b], cnt2[b]);
         end
      end
   endtask

   task automatic test_inject();
      idle();
      inj_req = 1'b1; inj_bank = 2'd1; inj_bit = 6'd3;
      tick();
      checks++;
      if (pend1 !== 1'b1 || pend2 !== 1'b1) begin
         errors++;
         $display("FAIL inj_arm: pend=%b%b, expected 11", pend1, pend2);
      end
      idle();
      set_bank(0, 1'b1, 0, '0, '0);
      tick();
      checks++;
      if (pend1 !== 1'b1) begin
         errors++;
         $display("FAIL inj_other_bank: pend=%b, expected 1", pend1);
      end
      idle();
      set_bank(1, 1'b1, 0, '0, '0);
      tick();
      checks++;
      if (pend1 !== 1'b0 || pend2 !== 1'b0) begin
         errors++;
         $display("FAIL inj_consume: pend=%b%b, expected 00", pend1, pend2);
      end
      idle();
      set_bank(0, 1'b0, 0, '0, '0);
      set_bank(1, 1'b0, 0, '0, '0);
      tick();
      checks++;
      if (vld1 !== 4'b0011 || dout1[0 +: DW] !== 32'h0 || dout1[DW +: DW] !== 32'h8 || ecc1[EW +: EW] !== 7'h0) begin
         errors++;
         $display("FAIL inj_flip_lat1: vld=%h b0=%h b1=%h ecc1=%h, expected 3/0/8/0",
                  vld1, dout1[0 +: DW], dout1[DW +: DW], ecc1[EW +: EW]);
      end
      idle();
      tick();
      checks++;
      if (dout2[0 +: DW] !== 32'h0 || dout2[DW +: DW] !== 32'h8) begin
         errors++;
         $display("FAIL inj_flip_lat2: b0=%h b1=%h, expected 0/8", dout2[0 +: DW], dout2[DW +: DW]);
      end
      // New request on the consuming edge: old target (ecc bit 3) used, new target stays armed.
      inj_req = 1'b1; inj_bank = 2'd3; inj_bit = 6'd35;
      tick();
      idle();
      set_bank(3, 1'b1, 1, '0, '0);
      inj_req = 1'b1; inj_bank = 2'd3; inj_bit = 6'd0;
      tick();
      checks++;
      if (pend1 !== 1'b1) begin
         errors++;
         $display("FAIL inj_coincident_pend: pend=%b, expected 1", pend1);
      end
      idle();
      set_bank(3, 1'b1, 2, '0, '0);
      tick();
      checks++;
      if (pend1 !== 1'b0) begin
         errors++;
         $display("FAIL inj_second_consume: pend=%b, expected 0", pend1);
      end
      idle();
      set_bank(3, 1'b0, 1, '0, '0);
      tick();
      checks++;
      if (dout1[3*DW +: DW] !== 32'h0 || ecc1[3*EW +: EW] !== 7'h08) begin
         errors++;
         $display("FAIL inj_old_target: data=%h ecc=%h, expected 0/08", dout1[3*DW +: DW], ecc1[3*EW +: EW]);
      end
      idle();
      set_bank(3, 1'b0, 2, '0, '0);
      tick();
      checks++;
      if (dout1[3*DW +: DW] !== 32'h1 || ecc1[3*EW +: EW] !== 7'h0) begin
         errors++;
         $display("FAIL inj_new_target: data=%h ecc=%h, expected 1/0", dout1[3*DW +: DW], ecc1[3*EW +: EW]);
      end
      idle();
      inj_req = 1'b1; inj_bank = 2'd0; inj_bit = 6'd39;
      tick();
      idle();
      set_bank(0, 1'b1, 3, 32'h12345678, 7'h11);
      tick();
      checks++;
      if (pend1 !== 1'b0) begin
         errors++;
         $display("FAIL inj_oob_consume: pend=%b, expected 0", pend1);
      end
      idle();
      set_bank(0, 1'b0, 3, '0, '0);
      tick();
      checks++;
      if (dout1[0 +: DW] !== 32'h12345678 || ecc1[0 +: EW] !== 7'h11) begin
         errors++;
         $display("FAIL inj_oob_noflip: data=%h ecc=%h, expected 12345678/11", dout1[0 +: DW], ecc1[0 +: EW]);
      end
      idle();
   endtask

   task automatic test_init_restart();
      int  n;
      logic any_v;
      idle();
      rst_l = 1'b0;
      #1;
      checks++;
      if (dout1 !== '0 || ecc1 !== '0 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_out: dout=%h ecc=%h done=%b, expected zero", dout1, ecc1, done1);
      end
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         idle();
         for (int b = 0; b < NB; b++) set_bank(b, 1'b0, 0, '0, '0);
         if (e == 3) begin
            inj_req = 1'b1; inj_bank = 2'd2; inj_bit = 6'd1;
         end
         tick();
         checks++;
         if (vld1 !== '0 || vld2 !== '0) begin
            errors++;
            $display("FAIL init_masked_read cyc %0d: vld=%h/%h, expected 0/0", e, vld1, vld2);
         end
      end
      checks++;
      if (pend1 !== 1'b1) begin
         errors++;
         $display("FAIL inj_during_init: pend=%b, expected 1", pend1);
      end
      idle();
      rst_l = 1'b0;
      #1;
      checks++;
      if ({done1, done2, pend1, pend2} !== 4'b0 || vld1 !== '0 || vld2 !== '0 || dout2 !== '0) begin
         errors++;
         $display("FAIL mid_init_reset: done=%b%b pend=%b%b vld=%h/%h dout2=%h, expected zero",
                  done1, done2, pend1, pend2, vld1, vld2, dout2);
      end
      #2;
      rst_l = 1'b1;
      n = 0;
      any_v = 1'b0;
      while (!done1 && n < 40) begin
         idle();
         if (n == 11) set_bank(1, 1'b1, 2, 32'hFFFFFFFF, 7'h7F);
         tick();
         n++;
         any_v = any_v | (|vld1) | (|vld2);
      end
      checks++;
      if (n !== 17 || any_v !== 1'b0) begin
         errors++;
         $display("FAIL restart_latency: init_done after %0d cycles valid_seen=%b, expected 17/0", n, any_v);
      end
      idle();
      set_bank(1, 1'b0, 2, '0, '0);
      tick();
      checks++;
      if (vld1 !== 4'b0010 || dout1[DW +: DW] !== 32'h0 || ecc1[EW +: EW] !== 7'h0) begin
         errors++;
         $display("FAIL init_write_ignored: vld=%h data=%h ecc=%h, expected 2/0/0",
                  vld1, dout1[DW +: DW], ecc1[EW +: EW]);
      end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_init_zero();
      test_write_read();
      test_back_to_back();
      test_inject();
      test_init_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
